// File: rtl/lsu_seq_ctrl.sv
`default_nettype none
// lsu_seq_ctrl: one-at-a-time load/store sequencer onto the data-SRAM req/addr_ok/data_ok bus.
// Rev 1.0
module lsu_seq_ctrl #(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int RESP_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_ld,
  input  logic              ex_st,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [31:0]       ex_addr,
  input  logic [RESP_W-1:0] ex_wdata,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_addr,
  output logic [RESP_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [RESP_W-1:0] data_rdata,
  output logic              ms_valid,
  input  logic              ms_ready,
  output logic [RESP_W-1:0] ms_rdata,
  output logic              ms_ale
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [RESP_W-1:0] wdata_q, wdata_d;
  logic [RESP_W-1:0] rdata_q, rdata_d;
  logic              ale_q, ale_d;

  logic              accept;
  logic              misalign;
  logic [3:0]        strb_new;
  logic [RESP_W-1:0] wdata_new;
  logic [RESP_W-1:0] ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign ex_ready = (state_q == IDLE) && !flush;
  assign accept   = ex_valid && ex_ready && (ex_ld || ex_st);
  assign misalign = ALIGN_CHECK &&
                    (((ex_size == 2'd1) && ex_addr[0]) ||
                     (ex_size[1] && (ex_addr[1:0] != 2'b00)));

  always_comb begin
    strb_new  = 4'b1111;
    wdata_new = ex_wdata;
    case (ex_size)
      2'd0: begin
        strb_new  = 4'b0001 << ex_addr[1:0];
        wdata_new = {4{ex_wdata[7:0]}};
      end
      2'd1: begin
        strb_new  = ex_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the latched address; the response belongs to the latched op.
  assign ld_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = data_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = data_rdata;
    case (size_q)
      2'd0:    ld_ext = {{(RESP_W-8){~uns_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{(RESP_W-16){~uns_q & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ale_d   = ale_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = ex_st && !ex_ld;
          size_d  = ex_size;
          uns_d   = ex_unsigned;
          addr_d  = ex_addr;
          wstrb_d = (ex_st && !ex_ld) ? strb_new : 4'b0000;
          wdata_d = wdata_new;
          rdata_d = '0;
          ale_d   = misalign;
          state_d = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        if (flush)             state_d = data_addr_ok ? DRAIN : IDLE;
        else if (data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_d = data_data_ok ? IDLE : DRAIN;
        end else if (data_data_ok) begin
          rdata_d = wr_q ? '0 : ld_ext;
          ale_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush || ms_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ale_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ale_q   <= ale_d;
    end
  end

  assign data_req   = (state_q == REQ);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_wstrb = wstrb_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign ms_valid   = (state_q == DONE);
  assign ms_rdata   = rdata_q;
  assign ms_ale     = ale_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_seq_ctrl.sv
`default_nettype none
// tb_lsu_seq_ctrl: directed test-plan cases plus randomized ops against a transaction-level model.
// Rev 1.0
module tb_lsu_seq_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_ready, ex_ld, ex_st, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        flush;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        ms_valid, ms_ready, ms_ale;
  logic [31:0] ms_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_seq_ctrl #(.ALIGN_CHECK(1'b1), .RESP_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ld(ex_ld), .ex_st(ex_st),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ms_valid(ms_valid), .ms_ready(ms_ready), .ms_rdata(ms_rdata), .ms_ale(ms_ale)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pure arithmetic on access width n = 2**size bytes.
  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int n = 1 << sz;
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input bit st, input logic [1:0] sz, input logic [31:0] a);
    int n = 1 << sz;
    int off = a % 4;
    if (!st) return 4'b0000;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int n = 1 << sz;
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    int n = 1 << sz;
    longint span = longint'(1) << (8 * n);
    longint v = (longint'(rd) >> (8 * (a % 4))) % span;
    if (!uns && n < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; ex_ld = 0; ex_st = 0; ex_size = 0; ex_unsigned = 0;
    ex_addr = 0; ex_wdata = 0; flush = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0; ms_ready = 0;
  endtask

  task automatic drain(input int d);
    for (int i = 0; i <= d; i++) begin
      check_val("drain_req", 32'(data_req), 32'd0);
      check_val("drain_rdy", 32'(ex_ready), 32'd0);
      check_val("drain_msv", 32'(ms_valid), 32'd0);
      flush = 1'($urandom);
      data_data_ok = (i == d);
      data_rdata = $urandom;
      @(negedge clk);
      data_data_ok = 0; flush = 0;
    end
    check_val("drain_exit_rdy", 32'(ex_ready), 32'd1);
    check_val("drain_exit_msv", 32'(ms_valid), 32'd0);
  endtask

  // fl: 0 none, 1 REQ w/o addr_ok, 2 REQ with addr_ok, 3 WAIT with data_ok,
  //     4 WAIT w/o data_ok, 5 DONE
  task automatic run_op(input bit ld, input bit both, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int aok_d, input int dok_d, input int rdy_d, input int drn_d,
                        input int fl);
    bit          mis  = m_misaligned(sz, a);
    logic [31:0] eres = (mis || !ld) ? 32'd0 : m_load(sz, uns, a, rd);
    @(negedge clk);
    check_val("idle_rdy", 32'(ex_ready), 32'd1);
    check_val("idle_msv", 32'(ms_valid), 32'd0);
    ex_valid = 1; ex_ld = ld; ex_st = ld ? both : 1'b1;
    ex_size = sz; ex_unsigned = uns; ex_addr = a; ex_wdata = wd;
    @(negedge clk);
    ex_valid = 0; ex_addr = $urandom; ex_wdata = $urandom; ex_size = 2'($urandom);
    ex_unsigned = 1'($urandom); ex_ld = 1'($urandom); ex_st = 1'($urandom);
    if (mis) begin
      check_val("ale_req", 32'(data_req), 32'd0);
    end else begin
      for (int i = 0; i <= aok_d; i++) begin
        check_val("req", 32'(data_req), 32'd1);
        check_val("req_wr", 32'(data_wr), 32'(!ld));
        check_val("req_size", 32'(data_size), 32'(sz));
        check_val("req_addr", data_addr, a);
        check_val("req_strb", 32'(data_wstrb), 32'(m_strb(!ld, sz, a)));
        if (!ld) check_val("req_wdata", data_wdata, m_wdata(sz, wd));
        check_val("req_msv", 32'(ms_valid), 32'd0);
        check_val("req_rdy", 32'(ex_ready), 32'd0);
        data_addr_ok = (i == aok_d) && (fl != 1);
        flush = (i == aok_d) && (fl == 1 || fl == 2);
        @(negedge clk);
        data_addr_ok = 0; flush = 0;
      end
      if (fl == 1) begin
        check_val("fl_req_req", 32'(data_req), 32'd0);
        check_val("fl_req_rdy", 32'(ex_ready), 32'd1);
        return;
      end
      if (fl == 2) begin drain(drn_d); return; end
      for (int j = 0; j <= dok_d; j++) begin
        check_val("wait_req", 32'(data_req), 32'd0);
        check_val("wait_msv", 32'(ms_valid), 32'd0);
        check_val("wait_rdy", 32'(ex_ready), 32'd0);
        data_data_ok = (j == dok_d) && (fl != 4);
        data_rdata = (j == dok_d) ? rd : $urandom;
        flush = (j == dok_d) && (fl == 3 || fl == 4);
        @(negedge clk);
        data_data_ok = 0; flush = 0; data_rdata = $urandom;
      end
      if (fl == 3) begin
        check_val("fl_wait_msv", 32'(ms_valid), 32'd0);
        check_val("fl_wait_rdy", 32'(ex_ready), 32'd1);
        return;
      end
      if (fl == 4) begin drain(drn_d); return; end
    end
    for (int k = 0; k <= rdy_d; k++) begin
      check_val("done_msv", 32'(ms_valid), 32'd1);
      check_val("done_rdata", ms_rdata, eres);
      check_val("done_ale", 32'(ms_ale), 32'(mis));
      check_val("done_req", 32'(data_req), 32'd0);
      check_val("done_rdy", 32'(ex_ready), 32'd0);
      if (k == rdy_d && fl == 5) begin flush = 1; ms_ready = 1'($urandom); end
      else ms_ready = (k == rdy_d);
      @(negedge clk);
      ms_ready = 0; flush = 0;
    end
    check_val("end_msv", 32'(ms_valid), 32'd0);
    check_val("end_rdy", 32'(ex_ready), 32'd1);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    ex_valid = 1; ex_ld = 0; ex_st = 1; ex_size = 2; ex_unsigned = 0;
    ex_addr = 32'h0000_4444; ex_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    ex_valid = 0;
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0;
    check_val("rst_pre_addr", data_addr, 32'h0000_4444);
    #2 resetn = 0;
    #1;
    check_val("rst_async_rdy", 32'(ex_ready), 32'd1);
    check_val("rst_async_req", 32'(data_req), 32'd0);
    check_val("rst_async_addr", data_addr, 32'd0);
    check_val("rst_async_strb", 32'(data_wstrb), 32'd0);
    check_val("rst_async_wdata", data_wdata, 32'd0);
    check_val("rst_async_wr", 32'(data_wr), 32'd0);
    check_val("rst_async_msv", 32'(ms_valid), 32'd0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    check_val("rst_after_msv", 32'(ms_valid), 32'd0);
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    #13;
    check_val("reset_rdy", 32'(ex_ready), 32'd1);
    check_val("reset_req", 32'(data_req), 32'd0);
    check_val("reset_msv", 32'(ms_valid), 32'd0);
    check_val("reset_ale", 32'(ms_ale), 32'd0);
    check_val("reset_rdata", ms_rdata, 32'd0);
    check_val("reset_strb", 32'(data_wstrb), 32'd0);
    @(negedge clk);
    resetn = 1;

    run_op(1, 0, 2, 0, 32'h1000, 0, 32'h8765_4321, 0, 0, 0, 0, 0);
    run_op(1, 0, 0, 0, 32'h1003, 0, 32'h8012_3456, 0, 0, 0, 0, 0);
    run_op(1, 0, 0, 1, 32'h1003, 0, 32'h8012_3456, 0, 0, 0, 0, 0);
    run_op(0, 0, 1, 0, 32'h2002, 32'h0000_BEEF, 0, 0, 0, 0, 0, 0);
    run_op(1, 0, 2, 0, 32'h3001, 0, 0, 0, 0, 0, 0, 0);
    run_op(1, 0, 2, 0, 32'h3008, 0, 32'h1234_5678, 3, 0, 0, 2, 4);
    run_op(1, 1, 1, 0, 32'h5002, 0, 32'hF00F_1234, 0, 1, 4, 0, 0);
    reset_mid_wait();

    for (int n = 0; n < 200; n++) begin
      bit          ld = 1'($urandom);
      logic [1:0]  sz = 2'($urandom_range(0, 2));
      logic [31:0] a  = $urandom;
      int          fl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_op(ld, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/lsu_seq_ctrl.md
Name: lsu_seq_ctrl

Overview:
Sequences one load/store at a time from the EX stage onto the CPU data-SRAM request interface (req / addr_ok / data_ok). It performs the following:
- generates byte strobes and replicated write data;
- checks alignment;
- extracts and sign/zero-extends load data;
- holds the result until the MEM/WB stage accepts it.

A pipeline flush cancels the access cleanly, including any response already in flight.

Parameters:
ALIGN_CHECK, 1, 1 = misaligned half/word raises ale and issues no bus request; 0 = no check, low address bits pass through.
RESP_W, 32, width of load result and store data; fixed at 32 for LA32R.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ex_valid  in  1  EX holds a memory op
ex_ready  out  1  controller accepts the op this cycle
ex_ld  in  1  op is a load
ex_st  in  1  op is a store (ex_ld and ex_st both 1 is illegal: treat as load)
ex_size  in  2  0 byte, 1 half, 2 word
ex_unsigned  in  1  zero-extend load (ld.bu/ld.hu)
ex_addr  in  32  effective address
ex_wdata  in  32  store data (low bits significant)
flush  in  1  cancel the current access
data_req  out  1  request valid
data_wr  out  1  1 = write
data_size  out  2  copy of ex_size
data_wstrb  out  4  byte enables (0 on reads)
data_addr  out  32  address
data_wdata  out  32  replicated store data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response/write-ack valid
data_rdata  in  32  read data
ms_valid  out  1  result/completion valid
ms_ready  in  1  MEM/WB accepts
ms_rdata  out  32  extended load data (0 for stores)
ms_ale  out  1  alignment exception

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0 except ex_ready=1; latched op fields cleared. Reset mid-access drops everything, with no recovery of the pending data_ok.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- ex_ready=1 only in IDLE with flush=0. Accept = ex_valid & ex_ready & (ex_ld|ex_st). The op is latched; latched fields drive data_*.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0. On misalignment with ALIGN_CHECK=1:
  - IDLE->DONE with ms_ale=1 and ms_rdata=0;
  - no data_req is ever asserted.
- IDLE->REQ on an aligned accept.
- data_req=1 exactly in REQ. Fields stay stable until data_addr_ok.
- REQ->WAIT on data_addr_ok.
- WAIT->DONE on data_data_ok:
  - capture the extended rdata (load) or 0 (store);
  - ms_valid=1 starting the next cycle.
- Earliest completion is 2 cycles after accept: REQ with addr_ok, then data_ok in the following cycle. data_ok in the same cycle as addr_ok is not supported; the slave never does this.
- DONE holds ms_* stable until ms_ready. On ms_ready: ms_valid clears next cycle and the FSM returns to IDLE. There is no back-to-back accept in the same cycle.
- Store strobes:
  - byte: 1<<addr[1:0];
  - half: 4'b0011 if addr[1]=0, else 4'b1100;
  - word: 4'b1111.
- Store data replication:
  - byte: wdata[7:0] x4;
  - half: wdata[15:0] x2;
  - word: as is.
- Load extraction:
  - byte: lane addr[1:0];
  - half: lane addr[1];
  - result is sign- or zero-extended per ex_unsigned.
- Flush:
  - IDLE: nothing accepted.
  - REQ without addr_ok: ->IDLE. The request is withdrawn next cycle; this is allowed before addr_ok.
  - REQ with addr_ok in the same cycle: ->DRAIN.
  - WAIT: if data_ok is present this cycle ->IDLE, else ->DRAIN.
  - DONE: ->IDLE and ms_valid drops.
  - DRAIN: data_req=0, ex_ready=0, ms_valid=0. Waits for data_ok, discards it, then ->IDLE. A further flush in DRAIN has no effect.
- Exactly one outstanding bus transaction ever.

Test Plan:
- Word load, addr 0x1000 (aligned), addr_ok immediately, data_ok next cycle with rdata 0x8765_4321 -> ms_valid 2 cycles after accept, ms_rdata=0x8765_4321, ms_ale=0.
- ld.b addr 0x1003, rdata 0x80xx_xxxx -> ms_rdata 0xFFFF_FF80; same with ex_unsigned=1 -> 0x0000_0080.
- st.h addr 0x2002, wdata 0x0000_BEEF -> data_wstrb=4'b1100, data_wdata=0xBEEF_BEEF, data_wr=1; completion with ms_rdata=0.
- ld.w addr 0x3001 -> data_req never 1, ms_valid=1 and ms_ale=1 the next cycle.
- addr_ok held low 3 cycles -> data_req and fields stable throughout. Flush in WAIT without data_ok -> DRAIN. data_ok 2 cycles later -> discarded, ms_valid never asserted, ex_ready=1 the cycle after.
- ms_ready low 4 cycles in DONE -> ms_* stable. resetn pulsed low mid-WAIT -> outputs reset to their reset values immediately, without waiting for a clock edge.
